// File: rtl/key_debounce_pkg.sv
// ---------------------------------------------------------------------------
// key_debounce_pkg
//  Shared types and constants for the push-button debouncer.
//  - key_rep_state_t : per-key auto-repeat FSM states
//  - KEY_RELEASED    : logic level of a released (idle) active-low button
//  - cnt_width()     : counter width large enough for every cycle count
// ---------------------------------------------------------------------------
package key_debounce_pkg;

   typedef enum logic [1:0] {
      RELEASED,
      PRESSED,
      BLIP,
      HELD
   } key_rep_state_t;

   localparam logic KEY_RELEASED = 1'b1;

   // Width that can hold the largest of the three cycle counts, plus one
   // spare bit so a terminal value never sits right at the wrap point.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// ---------------------------------------------------------------------------
// key_debounce_chan
//  One push-button channel: 2-FF synchroniser, stability filter and, when
//  KEY_DEBOUNCE_REPEAT_EN is defined, an auto-repeat FSM that re-creates a
//  falling edge on key_out while the key stays held.
//
//  Ports
//   clk        in  1  system clock
//   reset      in  1  synchronous, active-high reset
//   key_raw    in  1  asynchronous raw button, 0 = pressed
//   key_out    out 1  debounced level (plus repeat blips when enabled)
//   key_stable out 1  debounced level only
//
//  Configuration macro: KEY_DEBOUNCE_REPEAT_EN
// ---------------------------------------------------------------------------
module key_debounce_chan
   import key_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
`ifdef KEY_DEBOUNCE_REPEAT_EN
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000,
`endif
   parameter int CNT_W           = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic key_out,
   output logic key_stable
);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             stable_r;
   logic [CNT_W-1:0] deb_cnt;

   // Two-flop synchroniser. The raw button is asynchronous to clk, so only
   // the second stage is trusted by anything downstream. Both stages reset
   // to the released level so no false press appears after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= KEY_RELEASED;
         sync2 <= KEY_RELEASED;
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
      end
   end

   // Stability filter. deb_cnt counts consecutive cycles in which the
   // synchronised input disagrees with the accepted level; any agreement
   // clears it, so a bounce shorter than DEBOUNCE_CYCLES never gets through.
   // Once the disagreement has lasted the full window the new level is
   // accepted and the counter restarts from zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable_r <= KEY_RELEASED;
         deb_cnt  <= '0;
      end else if (sync2 == stable_r) begin
         deb_cnt  <= '0;
      end else if (deb_cnt == DEB_LAST) begin
         stable_r <= sync2;
         deb_cnt  <= '0;
      end else begin
         deb_cnt  <= deb_cnt + 1'b1;
      end
   end

   assign key_stable = stable_r;

`ifdef KEY_DEBOUNCE_REPEAT_EN

   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

   key_rep_state_t   state;
   key_rep_state_t   next_state;
   logic [CNT_W-1:0] rep_cnt;
   logic [CNT_W-1:0] next_rep_cnt;
   logic             out_r;
   logic             next_out;

   // Repeat FSM state register. key_out is registered alongside the state so
   // the PIO only ever sees a clean flop output, never a decode glitch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RELEASED;
         rep_cnt <= '0;
         out_r   <= KEY_RELEASED;
      end else begin
         state   <= next_state;
         rep_cnt <= next_rep_cnt;
         out_r   <= next_out;
      end
   end

   // Next-state logic. A released key wins over everything, including a
   // BLIP entry falling on the same edge, so a release never leaves a stray
   // repeat edge behind. While held, the counter times the first repeat
   // delay, then the shorter period between later repeats.
   always_comb begin
      next_state   = state;
      next_rep_cnt = rep_cnt;
      if (stable_r == KEY_RELEASED) begin
         next_state   = RELEASED;
         next_rep_cnt = '0;
      end else begin
         case (state)
            RELEASED: begin
               next_state   = PRESSED;
               next_rep_cnt = '0;
            end
            PRESSED: begin
               if (rep_cnt == DELAY_LAST) begin
                  next_state   = BLIP;
                  next_rep_cnt = '0;
               end else begin
                  next_rep_cnt = rep_cnt + 1'b1;
               end
            end
            BLIP: begin
               next_state   = HELD;
               next_rep_cnt = '0;
            end
            HELD: begin
               if (rep_cnt == PERIOD_LAST) begin
                  next_state   = BLIP;
                  next_rep_cnt = '0;
               end else begin
                  next_rep_cnt = rep_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   // Output decode. The key reads released in RELEASED and for the single
   // BLIP cycle; dropping back to pressed after BLIP is what gives the PIO
   // a fresh 1->0 edge to capture.
   always_comb begin
      next_out = ~KEY_RELEASED;
      if (next_state == RELEASED || next_state == BLIP) begin
         next_out = KEY_RELEASED;
      end
   end

   assign key_out = out_r;

`else

   assign key_out = stable_r;

`endif

endmodule

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//  Debounces and synchronises NUM_KEYS raw active-low push buttons before
//  they reach the key PIO in_port, so the PIO's falling-edge capture only
//  ever sees one clean edge per press.
//
//  Ports
//   clk        in  1         system clock (same clock as the key PIO)
//   reset      in  1         synchronous, active-high reset
//   key_raw    in  NUM_KEYS  asynchronous raw buttons, 0 = pressed
//   key_out    out NUM_KEYS  to PIO in_port; debounced level plus repeat
//                            pulses when auto-repeat is built in
//   key_stable out NUM_KEYS  debounced level only, never any repeat pulses
//
//  Configuration macro: KEY_DEBOUNCE_REPEAT_EN (adds per-key auto-repeat;
//  key_out then becomes registered and lags key_stable by one cycle)
// ---------------------------------------------------------------------------
module key_debounce
   import key_debounce_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000,
   parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_raw,
   output logic [NUM_KEYS-1:0] key_out,
   output logic [NUM_KEYS-1:0] key_stable
);

   // Every key is an independent channel with its own counters, so
   // simultaneous presses on different keys never interact.
   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
      key_debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef KEY_DEBOUNCE_REPEAT_EN
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
`endif
         .CNT_W           (CNT_W)
      ) u_chan (
         .clk        (clk),
         .reset      (reset),
         .key_raw    (key_raw[i]),
         .key_out    (key_out[i]),
         .key_stable (key_stable[i])
      );
   end

endmodule

// File: tb/tb_key_debounce.sv
// ---------------------------------------------------------------------------
// tb_key_debounce
//  Self-checking bench for key_debounce with short timing parameters.
//  A sliding-window reference model predicts key_stable/key_out on every
//  edge; predictions go through a scoreboard queue and are compared half a
//  cycle later. Table-driven segments plus hand-written corner sequences.
// ---------------------------------------------------------------------------
module tb_key_debounce;

   localparam int NUM_KEYS   = 4;
   localparam int DEB        = 8;
   localparam int RD         = 20;
   localparam int RP         = 10;
   localparam int HW         = DEB + 2;
   localparam int REP_FIRST  = RD + 1;
   localparam int REP_STEP   = RP + 1;

   logic                clk = 1'b0;
   logic                reset;
   logic [NUM_KEYS-1:0] key_raw;
   logic [NUM_KEYS-1:0] key_out;
   logic [NUM_KEYS-1:0] key_stable;

   key_debounce #(
      .NUM_KEYS        (NUM_KEYS),
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key_raw    (key_raw),
      .key_out    (key_out),
      .key_stable (key_stable)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] stable;
      logic [3:0] out;
   } exp_t;

   typedef struct {
      logic       rst;
      logic [3:0] raw;
      int         cycles;
      logic [3:0] exp_stable;
      logic [3:0] exp_out;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   int         cycle  = 0;
   exp_t       sb_q[$];
   logic [HW-1:0] m_hist [NUM_KEYS];
   logic [3:0] m_stable;
   int         m_since [NUM_KEYS];
   logic [3:0] obs_stable;
   logic [3:0] obs_out;

   vec_t       vecs [9];
   int         first;
   int         first3;
   int         falls;
   int         fall_at;
   int         low_cnt;
   int         bad_cnt;
   logic       prev;
   logic [3:0] raw_v;
   int         blips[$];

   // Reference model: a key's accepted level flips once the synchronised
   // history (raw delayed two edges) has shown the opposite level for DEB
   // consecutive samples. Repeat blips are predicted purely from the
   // number of edges since the accepted level fell.
   function automatic exp_t modelEdge(input logic rst, input logic [3:0] raw);
      exp_t       e;
      logic [3:0] old;
      old = m_stable;
      e   = '0;
      if (rst) begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            m_hist[k]  = '1;
            m_since[k] = 0;
         end
         m_stable = '1;
         e.out    = '1;
      end else begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            m_hist[k]  = {m_hist[k][HW-2:0], raw[k]};
            m_since[k] = m_since[k] + 1;
            if (m_hist[k][HW-1:2] == {DEB{~m_stable[k]}})
               m_stable[k] = ~m_stable[k];
            if (old[k] && !m_stable[k])
               m_since[k] = 0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
            e.out[k] = old[k] ? 1'b1 :
                       ((m_since[k] >= REP_FIRST) &&
                        ((m_since[k] - REP_FIRST) % REP_STEP == 0));
`else
            e.out[k] = m_stable[k];
`endif
         end
      end
      e.stable = m_stable;
      return e;
   endfunction

   task automatic checkValue(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s @cycle %0d: got %0h expected %0h",
                  name, cycle, act, exp);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      cycle++;
      obs_stable = key_stable;
      obs_out    = key_out;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard @cycle %0d: got empty queue expected entry", cycle);
      end else begin
         e = sb_q.pop_front();
         checkValue("key_stable", {28'd0, obs_stable}, {28'd0, e.stable});
         checkValue("key_out",    {28'd0, obs_out},    {28'd0, e.out});
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic [3:0] raw);
      reset   = rst;
      key_raw = raw;
      @(posedge clk);
      sb_q.push_back(modelEdge(rst, raw));
      @(negedge clk);
      checkOutput();
   endtask

   task automatic runCycles(input logic rst, input logic [3:0] raw, input int n);
      for (int i = 0; i < n; i++) applyStimulus(rst, raw);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset   = 1'b1;
      key_raw = 4'h0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         m_hist[k]  = '1;
         m_since[k] = 0;
      end
      m_stable = '1;

      vecs[0] = '{1'b1, 4'h0,  3, 4'hF, 4'hF};
      vecs[1] = '{1'b0, 4'hF, 10, 4'hF, 4'hF};
      vecs[2] = '{1'b0, 4'hE, 12, 4'hE, 4'hE};
      vecs[3] = '{1'b0, 4'hF, 12, 4'hF, 4'hF};
      vecs[4] = '{1'b0, 4'h0, 12, 4'h0, 4'h0};
      vecs[5] = '{1'b0, 4'hF, 12, 4'hF, 4'hF};
      vecs[6] = '{1'b0, 4'h5, 12, 4'h5, 4'h5};
      vecs[7] = '{1'b0, 4'hA, 12, 4'hA, 4'hA};
      vecs[8] = '{1'b0, 4'hF, 12, 4'hF, 4'hF};

      for (int i = 0; i < 9; i++) begin
         runCycles(vecs[i].rst, vecs[i].raw, vecs[i].cycles);
         checkValue($sformatf("vec%0d_stable", i), {28'd0, obs_stable}, {28'd0, vecs[i].exp_stable});
         checkValue($sformatf("vec%0d_out", i),    {28'd0, obs_out},    {28'd0, vecs[i].exp_out});
      end

      // Clean press on key 0: level must fall on exactly the 10th edge.
      first = 0;
      for (int i = 1; i <= 14; i++) begin
         applyStimulus(1'b0, 4'hE);
         if (first == 0 && obs_stable[0] == 1'b0) first = i;
      end
      checkValue("press_latency", first, 10);
      runCycles(1'b0, 4'hF, 12);

      // Bounce on key 1: toggle every 3 cycles, then settle low.
      falls   = 0;
      fall_at = 0;
      prev    = obs_stable[1];
      for (int seg = 0; seg < 10; seg++) begin
         raw_v    = 4'hF;
         raw_v[1] = (seg % 2 == 1);
         for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, raw_v);
            if (prev && !obs_stable[1]) falls++;
            prev = obs_stable[1];
         end
      end
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(1'b0, 4'hD);
         if (prev && !obs_stable[1]) begin
            falls++;
            fall_at = i;
         end
         prev = obs_stable[1];
      end
      checkValue("bounce_falls", falls, 1);
      checkValue("bounce_latency", fall_at, 10);
      runCycles(1'b0, 4'hF, 12);

      // Glitches on key 2: 7 cycles is filtered, 8 cycles passes as 8.
      low_cnt = 0;
      for (int i = 0; i < 21; i++) begin
         applyStimulus(1'b0, (i < 7) ? 4'hB : 4'hF);
         if (!obs_stable[2]) low_cnt++;
      end
      checkValue("glitch7_low", low_cnt, 0);
      low_cnt = 0;
      for (int i = 0; i < 22; i++) begin
         applyStimulus(1'b0, (i < 8) ? 4'hB : 4'hF);
         if (!obs_stable[2]) low_cnt++;
      end
      checkValue("glitch8_low", low_cnt, 8);

      // Independence: key 0 pressed two cycles ahead of key 3.
      first  = 0;
      first3 = 0;
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(1'b0, (i <= 2) ? 4'hE : 4'h6);
         if (first == 0 && !obs_stable[0])  first  = i;
         if (first3 == 0 && !obs_stable[3]) first3 = i;
      end
      checkValue("indep_key0", first, 10);
      checkValue("indep_key3", first3, 12);
      runCycles(1'b0, 4'hF, 12);

      // Reset while key 0's counter sits at 5: nothing may reach the outputs.
      bad_cnt = 0;
      for (int i = 0; i < 21; i++) begin
         applyStimulus((i >= 7 && i < 9), (i < 7) ? 4'hE : 4'hF);
         if (obs_stable != 4'hF || obs_out != 4'hF) bad_cnt++;
      end
      checkValue("reset_midcount", bad_cnt, 0);

`ifdef KEY_DEBOUNCE_REPEAT_EN
      // Auto-repeat: blips at +21, +32, +43, +54 after the level falls.
      first = 0;
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(1'b0, 4'hE);
         if (!obs_stable[0]) begin
            first = i;
            break;
         end
      end
      checkValue("rep_fall", first, 10);
      for (int k = 1; k <= 60; k++) begin
         applyStimulus(1'b0, 4'hE);
         if (obs_out[0]) blips.push_back(k);
      end
      checkValue("rep_blip_count", blips.size(), 4);
      for (int j = 0; j < 4; j++) begin
         if (j < blips.size())
            checkValue($sformatf("rep_blip%0d", j), blips[j], REP_FIRST + REP_STEP * j);
      end
      bad_cnt = 0;
      prev    = 1'b0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 4'hF);
         if (prev && !obs_out[0]) bad_cnt++;
         prev = obs_stable[0];
      end
      checkValue("rep_release_blips", bad_cnt, 0);
      checkValue("rep_release_out", {31'd0, obs_out[0]}, 1);
`else
      // No repeat: key_out stays low for the whole hold after the fall.
      bad_cnt = 0;
      for (int i = 1; i <= 70; i++) begin
         applyStimulus(1'b0, 4'hE);
         if (i >= 10 && obs_out[0]) bad_cnt++;
      end
      checkValue("norep_hold", bad_cnt, 0);
      runCycles(1'b0, 4'hF, 12);
      checkValue("norep_release_out", {31'd0, obs_out[0]}, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
